// File: rtl/fib_ctrl.sv
// fib_ctrl: drives a 4-phase dual-rail Fibonacci generator and returns binary
// terms on a valid/ready port. Define FIB_CTRL_ILLEGAL_CHK_EN for a sticky err output.
//
// fib_out packing: bit i of the word uses fib_out[2*i] (rail 0, logic 0) and
// fib_out[2*i+1] (rail 1, logic 1). 00 = null, 11 = illegal.
module fib_ctrl #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CNT_W-1:0]   cmd_count,
    output logic               fib_start,
    output logic               fib_ack,
    input  logic [2*WIDTH-1:0] fib_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_last,
    output logic               busy
`ifdef FIB_CTRL_ILLEGAL_CHK_EN
    ,
    output logic               err
`endif
);

    // A single-stage synchronizer is never safe, so clamp to two.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN_DATA,
        S_RUN_NULL,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_N-1:0][2*WIDTH-1:0] r_sync;
    logic [2*WIDTH-1:0]             w_syn;
    logic [2*WIDTH-1:0]             r_prev;
    logic [WIDTH-1:0]               w_dec;
    logic                           w_complete;
    logic                           w_null;
    logic                           w_take;

    logic [CNT_W-1:0] r_rem;
    logic             r_start;
    logic             r_ack;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_last;

    logic w_load;
    logic w_latch;
    logic w_ack_clr;
    logic w_abort;
    logic w_hshk;

`ifdef FIB_CTRL_ILLEGAL_CHK_EN
    logic w_ill_any;
    logic r_ill_prev;
    logic w_ill_det;
    logic r_err;
`endif

    assign w_syn  = r_sync[SYNC_N-1];
    assign w_hshk = r_res_valid && res_ready;

    // Every rail passes through SYNC_N flops before any use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], fib_out};
        end
    end

    // Classify the synchronized word and decode rail 1 to binary.
    always_comb begin
        w_complete = 1'b1;
        w_null     = 1'b1;
        w_dec      = '0;
`ifdef FIB_CTRL_ILLEGAL_CHK_EN
        w_ill_any  = 1'b0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            w_dec[i] = w_syn[2*i+1];
            if (w_syn[2*i] == w_syn[2*i+1]) begin
                w_complete = 1'b0;
            end
            if (w_syn[2*i] || w_syn[2*i+1]) begin
                w_null = 1'b0;
            end
`ifdef FIB_CTRL_ILLEGAL_CHK_EN
            if (w_syn[2*i] && w_syn[2*i+1]) begin
                w_ill_any = 1'b1;
            end
`endif
        end
    end

    // Previous synchronized word, used to reject a word still settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_syn;
        end
    end

    // Complete and unchanged for two cycles: the word has settled.
    assign w_take = w_complete && (w_syn == r_prev);

`ifdef FIB_CTRL_ILLEGAL_CHK_EN
    // Illegal code seen two cycles running latches a sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_prev <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ill_prev <= w_ill_any;
            if (w_ill_det) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_ill_det = w_ill_any && r_ill_prev;
    assign err       = r_err;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and one-cycle control strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_latch     = 1'b0;
        w_ack_clr   = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid && (cmd_count != '0)) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN_DATA;
                end
            end
            S_RUN_DATA: begin
                if (w_take && !r_res_valid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_RUN_NULL;
                end
            end
            S_RUN_NULL: begin
                if (w_null) begin
                    w_ack_clr = 1'b1;
                    if (r_rem != '0) begin
                        w_state_nxt = S_RUN_DATA;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!r_res_valid || res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
`ifdef FIB_CTRL_ILLEGAL_CHK_EN
        if (w_ill_det &&
            ((r_state == S_RUN_DATA) || (r_state == S_RUN_NULL))) begin
            w_latch     = 1'b0;
            w_ack_clr   = 1'b0;
            w_abort     = 1'b1;
            w_state_nxt = S_DRAIN;
        end
`endif
    end

    // Remaining-term counter; only decremented on a latch, so never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
        end else if (w_load) begin
            r_rem <= cmd_count;
        end else if (w_latch) begin
            r_rem <= r_rem - CNT_W'(1);
        end
    end

    // Generator start: up for the command, down with the last latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= 1'b0;
        end else if (w_load) begin
            r_start <= 1'b1;
        end else if (w_abort) begin
            r_start <= 1'b0;
        end else if (w_latch && (r_rem == CNT_W'(1))) begin
            r_start <= 1'b0;
        end
    end

    // 4-phase ack: rises on latch, falls once null is observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
        end else if (w_latch) begin
            r_ack <= 1'b1;
        end else if (w_ack_clr || w_abort) begin
            r_ack <= 1'b0;
        end
    end

    // Result register: filled on latch, held under stall, cleared on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_last  <= 1'b0;
        end else if (w_latch) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_dec;
            r_res_last  <= (r_rem == CNT_W'(1));
        end else if (w_hshk) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_last  <= 1'b0;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign fib_start = r_start;
    assign fib_ack   = r_ack;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_last  = r_res_last;

endmodule

// File: tb/tb_fib_ctrl.sv
// tb_fib_ctrl: random and directed bench for fib_ctrl with a dual-rail
// Fibonacci generator model and a queue scoreboard.
module tb_fib_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam int SYNC  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic [CNT_W-1:0]   cmd_count = '0;
    logic               res_ready = 1'b0;
    logic               cmd_ready;
    logic               fib_start;
    logic               fib_ack;
    logic               res_valid;
    logic [WIDTH-1:0]   res_data;
    logic               res_last;
    logic               busy;
    logic [2*WIDTH-1:0] g_out = '0;
    logic [2*WIDTH-1:0] ill_or = '0;
    logic [2*WIDTH-1:0] fib_out;
`ifdef FIB_CTRL_ILLEGAL_CHK_EN
    logic               err;
`endif

    assign fib_out = g_out | ill_or;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    exp_t sb[$];

    fib_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_count(cmd_count),
        .fib_start(fib_start),
        .fib_ack(fib_ack),
        .fib_out(fib_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_last(res_last),
        .busy(busy)
`ifdef FIB_CTRL_ILLEGAL_CHK_EN
        ,
        .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // k-th Fibonacci term, sequence 1,1,2,3,5,...
    function automatic logic [WIDTH-1:0] fib_ref(input int k);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] t;
        a = '0;
        b = 1;
        for (int j = 1; j < k; j++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    // Behavioural dual-rail generator with per-bit rail skew.
    int               g_phase = 0;
    logic [WIDTH-1:0] g_a = '0;
    logic [WIDTH-1:0] g_b = 1;
    logic [WIDTH-1:0] g_t;
    int               g_dly[WIDTH];
    int               g_cnt = 0;
    int               skew_max = 0;
    bit               gen_en = 1'b1;
    int               n_lat = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            g_phase = 0;
            g_a = '0;
            g_b = 1;
            g_out = '0;
        end else begin
            case (g_phase)
                0: begin
                    if (!fib_start) begin
                        g_a = '0;
                        g_b = 1;
                    end else if (gen_en && !fib_ack) begin
                        for (int i = 0; i < WIDTH; i++)
                            g_dly[i] = int'($urandom_range(skew_max, 0));
                        g_cnt = 0;
                        g_phase = 1;
                    end
                end
                1: begin
                    if (fib_ack) begin
                        n_lat++;
                        g_out = '0;
                        g_t = g_a + g_b;
                        g_a = g_b;
                        g_b = g_t;
                        g_phase = 2;
                    end else begin
                        for (int i = 0; i < WIDTH; i++)
                            if (g_dly[i] <= g_cnt)
                                g_out[2*i + int'(g_b[i])] = 1'b1;
                        g_cnt++;
                    end
                end
                default: begin
                    if (!fib_ack) g_phase = 0;
                end
            endcase
        end
    end

    // Consumer ready: 0 always high, 1 random, 2 held low.
    int rdy_mode = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: res_ready = 1'b1;
                1: res_ready = 1'($urandom_range(1, 0));
                default: res_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pops and stall-stability checks.
    logic [WIDTH-1:0] m_pd;
    logic             m_pl;
    bit               m_stall = 1'b0;
    exp_t             m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_stall = 1'b0;
        end else begin
            if (m_stall) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_data", res_data, m_pd);
                chk("hold_last", res_last, m_pl);
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_term actual=%0d expected=none",
                             res_data);
                end else begin
                    m_e = sb.pop_front();
                    chk("term_data", res_data, m_e.data);
                    chk("term_last", res_last, m_e.last);
                end
            end
            m_stall = res_valid && !res_ready;
            m_pd = res_data;
            m_pl = res_last;
        end
    end

    task automatic issue(input int n, input bit expect_out);
        int   w;
        exp_t e;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_count = CNT_W'(n);
        if (expect_out) begin
            for (int k = 1; k <= n; k++) begin
                e.data = fib_ref(k);
                e.last = (k == n);
                sb.push_back(e);
            end
        end
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("cmd_accept", (w < 200), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int w;
        w = 0;
        while ((busy || sb.size() != 0) && w < 4000) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk({name, "_done"}, (w < 4000), 1);
        chk({name, "_idle"}, cmd_ready, 1);
        chk({name, "_start_low"}, fib_start, 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_start"}, fib_start, 0);
        chk({name, "_ack"}, fib_ack, 0);
        chk({name, "_valid"}, res_valid, 0);
        chk({name, "_last"}, res_last, 0);
        chk({name, "_data"}, res_data, 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int w;
        bit seen_start;
        bit seen_valid;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 1);

        rdy_mode = 0;
        skew_max = 0;
        issue(5, 1);
        wait_done("cnt5");

        rdy_mode = 2;
        skew_max = 2;
        repeat (2) @(posedge clk);
        n0 = n_lat;
        issue(3, 1);
        w = 0;
        while (!res_valid && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("bp_first_valid", res_valid, 1);
        repeat (50) @(posedge clk);
        #1;
        chk("bp_ack_low", fib_ack, 0);
        chk("bp_held_valid", res_valid, 1);
        chk("bp_held_data", res_data, 1);
        chk("bp_one_ack", n_lat - n0, 1);
        rdy_mode = 0;
        wait_done("bp");

        issue(0, 0);
        seen_start = 1'b0;
        seen_valid = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (fib_start) seen_start = 1'b1;
            if (res_valid) seen_valid = 1'b1;
        end
        chk("cnt0_start", seen_start, 0);
        chk("cnt0_valid", seen_valid, 0);
        chk("cnt0_ready", cmd_ready, 1);

        rdy_mode = 1;
        skew_max = 7;
        issue(15, 1);
        wait_done("cntmax");

        for (int r = 0; r < 8; r++) begin
            rdy_mode = int'($urandom_range(1, 0));
            skew_max = int'($urandom_range(7, 0));
            issue(int'($urandom_range(15, 1)), 1);
            wait_done("rand");
        end

        rdy_mode = 0;
        skew_max = 3;
        n0 = n_lat;
        issue(4, 1);
        w = 0;
        while ((n_lat - n0) < 2 && w < 500) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("rst_reach_term2", (n_lat - n0), 2);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        chk("midrst_ready", cmd_ready, 1);
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(2, 1);
        wait_done("after_rst");

`ifdef FIB_CTRL_ILLEGAL_CHK_EN
        gen_en = 1'b0;
        issue(3, 0);
        repeat (5) @(posedge clk);
        #1;
        ill_or[15:14] = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        ill_or = '0;
        repeat (SYNC + 3) @(posedge clk);
        #1;
        chk("ill_err", err, 1);
        chk("ill_start", fib_start, 0);
        w = 0;
        while (busy && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("ill_idle", cmd_ready, 1);
        chk("ill_err_sticky", err, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib_ctrl.md
FIB_CTRL -- requirements
Module: fib_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data bits per term (generator word width).
REQ-002 Parameter CNT_W, default 16, width of term-count command.
REQ-003 Parameter SYNC_STAGES, default 2, flops per rail in input synchronizer (min 2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  input  1  request to generate cmd_count terms.
REQ-007 cmd_ready  output  1  high only in IDLE.
REQ-008 cmd_count  input  CNT_W  number of terms, sampled on cmd_valid&&cmd_ready.
REQ-009 fib_start  output  1  drives generator start (enables feedback barrier).
REQ-010 fib_ack  output  1  drives generator ack_i (4-phase return-to-zero).
REQ-011 fib_out  input  WIDTH x 2  dual-rail generator output; rail[0]=logic 0, rail[1]=logic 1, 00=null, 11=illegal.
REQ-012 res_valid  output  1  decoded term available.
REQ-013 res_ready  input  1  consumer accepts term.
REQ-014 res_data  output  WIDTH  binary term.
REQ-015 res_last  output  1  marks final term of command.
REQ-016 busy  output  1  high whenever state != IDLE.

Function
REQ-017 Each rail of fib_out SHALL pass through SYNC_STAGES flops before any use.
REQ-018 Word "complete" SHALL mean every bit has exactly one rail high; "null" SHALL mean all rails low.
REQ-019 Complete SHALL be accepted only when seen on 2 consecutive cycles with identical value (skew filter).
REQ-020 FSM states: IDLE, RUN_DATA, RUN_NULL, DRAIN.
REQ-021 IDLE: on cmd accept with count>0 -> RUN_DATA, load remaining=count, fib_start=1; count==0 accepted, stays IDLE, no output.
REQ-022 RUN_DATA: on filtered complete AND result register empty -> latch decoded word, res_valid=1, fib_ack=1, remaining-=1, -> RUN_NULL.
REQ-023 RUN_DATA with result register full SHALL hold fib_ack=0 (backpressure stalls generator).
REQ-024 Latch of term with remaining==1 SHALL set res_last=1 and drop fib_start the same cycle.
REQ-025 RUN_NULL: on null -> fib_ack=0; -> RUN_DATA if remaining>0, else DRAIN.
REQ-026 DRAIN: when res_valid&&res_ready (or register empty) -> IDLE.
REQ-027 res_data/res_last SHALL be stable while res_valid&&!res_ready; register clears on handshake.
REQ-028 Latency: stable complete at fib_out -> res_valid within SYNC_STAGES+2 cycles; null -> fib_ack low within SYNC_STAGES+1.
REQ-029 fib_ack SHALL never toggle twice without the opposite data phase observed in between.
REQ-030 remaining counter SHALL not wrap; count of 2^CNT_W-1 SHALL be served fully.

Reset
REQ-031 rst_n low SHALL force IDLE, fib_start=0, fib_ack=0, res_valid=0, res_last=0, res_data=0, busy=0, synchronizers=0, asynchronously.
REQ-032 Reset mid-command SHALL discard the command; generator SHALL be reset by the same system reset.
REQ-033 After release, cmd_ready SHALL be high on first clk edge.

Configuration
REQ-034 Macro FIB_CTRL_ILLEGAL_CHK_EN defined: output err (1 bit, sticky until reset) set when any synchronized bit is 11 for 2 consecutive cycles; FSM -> DRAIN, fib_start=0.
REQ-035 Macro undefined: no err port, 11 treated as incomplete, no check logic.

Verification
REQ-036 count=5, res_ready=1, behavioural generator -> terms 1,1,2,3,5 (seeding per generator INIT), res_last on 5th only, back to IDLE.
REQ-037 count=3, res_ready low 50 cycles after term 1 -> fib_ack stays 0 for term 2 until term 1 taken; no term lost or duplicated.
REQ-038 count=0 -> cmd accepted, fib_start never rises, no res_valid.
REQ-039 Per-bit random rail skew 0-7 cycles on complete -> latched value equals final word, never partial.
REQ-040 rst_n low during RUN_NULL of term 2 of 4 -> all outputs 0 immediately; new count=2 command completes correctly.
REQ-041 FIB_CTRL_ILLEGAL_CHK_EN: force bit 7 to 11 for 3 cycles -> err=1, fib_start=0, returns IDLE after drain.
